// File: rtl/stack_seq_if.sv
// Request/response and byte-wide memory bus for the 8085 stack sequencer.
// slave is the sequencer's view; master is the view of control plus memory.
interface stack_seq_if #(
  parameter int ADDRSIZE = 16,
  parameter int DATASIZE = 8
);
  logic                    req_valid;
  logic [1:0]              req_op;
  logic [2*DATASIZE-1:0]   req_data;
  logic                    req_ready;
  logic                    resp_valid;
  logic [2*DATASIZE-1:0]   resp_data;
  logic [ADDRSIZE-1:0]     sp_out;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRSIZE-1:0]     mem_addr;
  logic [DATASIZE-1:0]     mem_wdata;
  logic [DATASIZE-1:0]     mem_rdata;
  logic                    mem_ack;

  modport slave (
    input  req_valid, req_op, req_data, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_data, sp_out,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_data, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_data, sp_out,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_seq.sv
// 8085 stack-pointer sequencer: owns SP and splits each 16-bit PUSH/POP into
// two byte memory cycles, committing the SP +/-2 adjust once at completion.
module stack_seq #(
  parameter int                  ADDRSIZE = 16,
  parameter int                  DATASIZE = 8,
  parameter logic [ADDRSIZE-1:0] SP_RESET = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  stack_seq_if.slave  bus
);

  localparam int OPW = 2 * DATASIZE;
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [1:0] {IDLE, CYC1, CYC2, DONE} state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [OPW-1:0]        r_data;
  logic [ADDRSIZE-1:0]   r_sp;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [OPW-1:0]        r_resp_data;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDRSIZE-1:0]   r_mem_addr;
  logic [DATASIZE-1:0]   r_mem_wdata;

  // SP neighbours; all arithmetic wraps modulo 2^ADDRSIZE
  logic [ADDRSIZE-1:0]   w_sp_m1, w_sp_m2, w_sp_p1, w_sp_p2, w_load_sp;
  assign w_sp_m1   = r_sp - ADDRSIZE'(1);
  assign w_sp_m2   = r_sp - ADDRSIZE'(2);
  assign w_sp_p1   = r_sp + ADDRSIZE'(1);
  assign w_sp_p2   = r_sp + ADDRSIZE'(2);
  assign w_load_sp = ADDRSIZE'(bus.req_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_op         <= OP_PUSH;
      r_data       <= '0;
      r_sp         <= SP_RESET;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_op        <= bus.req_op;
            r_data      <= bus.req_data;
            r_req_ready <= 1'b0;
            if (bus.req_op == OP_PUSH) begin
              r_state     <= CYC1;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_sp_m1;
              r_mem_wdata <= bus.req_data[OPW-1:DATASIZE];
            end else if (bus.req_op == OP_POP) begin
              r_state     <= CYC1;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= r_sp;
            end else begin
              if (bus.req_op == OP_LOAD) r_sp <= w_load_sp;
              r_state <= DONE;
            end
          end
        end
        CYC1: begin
          // high byte goes first on PUSH so the stack grows down byte by byte
          if (bus.mem_ack) begin
            r_state <= CYC2;
            if (r_op == OP_PUSH) begin
              r_mem_addr  <= w_sp_m2;
              r_mem_wdata <= r_data[DATASIZE-1:0];
            end else begin
              r_mem_addr             <= w_sp_p1;
              r_data[DATASIZE-1:0]   <= bus.mem_rdata;
            end
          end
        end
        CYC2: begin
          if (bus.mem_ack) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_op == OP_POP) r_data[OPW-1:DATASIZE] <= bus.mem_rdata;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_data  <= (r_op == OP_POP) ? r_data : '0;
          if (r_op == OP_PUSH)     r_sp <= w_sp_m2;
          else if (r_op == OP_POP) r_sp <= w_sp_p2;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.sp_out     = r_sp;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: stack-level reference model feeding scoreboards that
// a memory responder and a response monitor consume independently.
module tb_stack_seq;
  localparam int          AW     = 16;
  localparam int          DW     = 8;
  localparam logic [15:0] SP_RST = 16'h0000;
  localparam logic [1:0]  PUSH = 2'b00, POP = 2'b01, LOAD = 2'b10, RSVD = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  initial forever #5 clk = ~clk;

  stack_seq_if #(.ADDRSIZE(AW), .DATASIZE(DW)) bus();
  stack_seq #(.ADDRSIZE(AW), .DATASIZE(DW), .SP_RESET(SP_RST)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct { logic [15:0] data; logic [15:0] sp; longint acc; int lat; } resp_t;
  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; logic [15:0] sp; } mcyc_t;

  resp_t      exp_q[$];
  mcyc_t      mq[$];
  logic [7:0] env_mem [logic [15:0]];
  logic [7:0] mdl_mem [logic [15:0]];
  logic [15:0] m_sp = SP_RST;
  int ack_delay = 0;
  bit stray_en  = 1'b0;
  int n_checks  = 0;
  int n_err     = 0;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] env_rd(input logic [15:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] mdl_rd(input logic [15:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_byte(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: stack semantics with wrapping 16-bit SP
  task automatic mdl_accept(input logic [1:0] op, input logic [15:0] d);
    resp_t r;
    int    lat_mem;
    lat_mem = (ack_delay >= 0) ? 2 * ack_delay + 3 : -1;
    r.acc  = longint'($time);
    r.data = 16'h0000;
    r.lat  = 1;
    case (op)
      PUSH: begin
        mq.push_back('{we: 1'b1, addr: m_sp - 16'd1, wdata: d[15:8], sp: m_sp});
        mq.push_back('{we: 1'b1, addr: m_sp - 16'd2, wdata: d[7:0],  sp: m_sp});
        mdl_mem[m_sp - 16'd1] = d[15:8];
        mdl_mem[m_sp - 16'd2] = d[7:0];
        m_sp  = m_sp - 16'd2;
        r.lat = lat_mem;
      end
      POP: begin
        mq.push_back('{we: 1'b0, addr: m_sp,         wdata: 8'h00, sp: m_sp});
        mq.push_back('{we: 1'b0, addr: m_sp + 16'd1, wdata: 8'h00, sp: m_sp});
        r.data = {mdl_rd(m_sp + 16'd1), mdl_rd(m_sp)};
        m_sp   = m_sp + 16'd2;
        r.lat  = lat_mem;
      end
      LOAD:    m_sp = d;
      default: ;
    endcase
    r.sp = m_sp;
    exp_q.push_back(r);
  endtask

  // Called on a negedge; returns on the negedge after the accept edge
  task automatic issue(input logic [1:0] op, input logic [15:0] d);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      mdl_accept(op, d);
      @(negedge clk);
      chk("ready_drop", {31'd0, bus.req_ready}, 32'd0);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data",  {16'd0, bus.resp_data},  32'd0);
    chk("rst_sp_out",     {16'd0, bus.sp_out},     {16'd0, SP_RST});
    chk("rst_mem_req",    {31'd0, bus.mem_req},    32'd0);
    chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("rst_mem_addr",   {16'd0, bus.mem_addr},   32'd0);
    chk("rst_mem_wdata",  {24'd0, bus.mem_wdata},  32'd0);
  endtask

  // Memory responder: checks each cycle against the expected cycle queue
  initial begin
    bit    in_cyc;
    int    cnt;
    mcyc_t e;
    logic [15:0] c_addr, c_sp;
    logic        c_we;
    logic [7:0]  c_wdata;
    in_cyc = 1'b0;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!rst_n) begin
        in_cyc = 1'b0;
      end else if (bus.mem_req) begin
        if (!in_cyc) begin
          in_cyc  = 1'b1;
          cnt     = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
          c_addr  = bus.mem_addr;
          c_we    = bus.mem_we;
          c_wdata = bus.mem_wdata;
          c_sp    = bus.sp_out;
          if (mq.size() == 0) begin
            chk("mem_unexpected", 32'd1, 32'd0);
          end else begin
            e = mq.pop_front();
            chk("mem_we",   {31'd0, bus.mem_we},   {31'd0, e.we});
            chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
            if (e.we) chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.wdata});
            chk("sp_hold", {16'd0, bus.sp_out}, {16'd0, e.sp});
          end
        end else begin
          chk("mem_addr_hold", {16'd0, bus.mem_addr}, {16'd0, c_addr});
          chk("mem_we_hold",   {31'd0, bus.mem_we},   {31'd0, c_we});
          if (c_we) chk("mem_wdata_hold", {24'd0, bus.mem_wdata}, {24'd0, c_wdata});
          chk("sp_stable", {16'd0, bus.sp_out}, {16'd0, c_sp});
        end
        if (cnt == 0) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = env_rd(bus.mem_addr);
          in_cyc = 1'b0;
        end else begin
          cnt--;
        end
      end else if (stray_en) begin
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
      end
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    int    lat;
    forever begin
      @(negedge clk);
      if (rst_n && bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e   = exp_q.pop_front();
          lat = int'((longint'($time) - 5 - e.acc) / 10);
          chk("resp_data",  {16'd0, bus.resp_data}, {16'd0, e.data});
          chk("resp_sp",    {16'd0, bus.sp_out},    {16'd0, e.sp});
          chk("resp_ready", {31'd0, bus.req_ready}, 32'd1);
          if (e.lat >= 0) chk("latency", lat, e.lat);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [7:0]  saved;
    logic [1:0]  op;
    logic [15:0] d;
    int          r;
    int          n;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_data  = 16'h0000;
    #1 rst_n = 1'b0;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed: load, 1-cycle push, slow pop
    ack_delay = 0;
    issue(LOAD, 16'h2000);  drain();
    issue(PUSH, 16'h1234);  drain();
    chk("mem_1fff", {24'd0, env_rd(16'h1FFF)}, 32'h12);
    chk("mem_1ffe", {24'd0, env_rd(16'h1FFE)}, 32'h34);
    ack_delay = 4;
    issue(POP, 16'h0000);   drain();

    // Wrap-around in both directions
    ack_delay = 0;
    issue(LOAD, 16'h0000);
    issue(PUSH, 16'hABCD);
    issue(POP,  16'h0000);
    issue(LOAD, 16'hFFFF);
    issue(POP,  16'h0000);
    issue(RSVD, 16'hFFFF);
    drain();

    // Held request during busy op, stray acks in idle
    stray_en = 1'b1;
    ack_delay = 1;
    issue(PUSH, 16'h55AA);
    issue(POP,  16'h0000);
    issue(LOAD, 16'h8000);
    drain();

    // Randomized traffic
    ack_delay = -1;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      d = 16'($urandom);
      if (r < 4)       op = PUSH;
      else if (r < 8)  op = POP;
      else if (r == 8) begin
        op = LOAD;
        if ($urandom_range(0, 1) == 1) d = 16'h0001;
      end else op = RSVD;
      issue(op, d);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // Reset during the second byte of a PUSH
    stray_en  = 1'b0;
    ack_delay = 2;
    issue(LOAD, 16'h2000);
    drain();
    saved = mdl_rd(16'h1FFE);
    issue(PUSH, 16'h5AA5);
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 16'h1FFE) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_cyc2", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    exp_q.delete();
    mq.delete();
    m_sp = SP_RST;
    mdl_mem[16'h1FFE] = saved;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst_n = 1'b1;
    issue(LOAD, 16'h1FFE);
    issue(POP,  16'h0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
